// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-ordered car controller with latched floor calls and door sequencing
module elevator_ctrl #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  emergency_stop,
  input  logic                  wait_complete,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  door_wait,
  output logic                  door_close,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  idle
);
  localparam int CNT_W = MOVE_CYCLES > 1 ? $clog2(MOVE_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_WAIT, DOOR_CLOSE} state_t;
  state_t state, state_n;
  logic [FLOOR_W-1:0] floor_q, floor_n, nf;
  logic [CNT_W-1:0] move_cnt, cnt_n;
  logic [NUM_FLOORS-1:0] pend_q, clr;
  logic dir_up, dir_n, arrive, hit_cur, hit_nf, above_cur, below_cur, above_nf, below_nf;
  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b1}} << f;
    return |(p & (m << 1));
  endfunction
  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b1}} << f;
    return |(p & ~m);
  endfunction
  // nf is the floor the car reaches when the current travel step completes
  assign nf        = state == MOVE_DOWN ? floor_q - 1'b1 : floor_q + 1'b1;
  assign arrive    = move_cnt == CNT_W'(MOVE_CYCLES - 1);
  assign hit_cur   = pend_q[floor_q];
  assign hit_nf    = pend_q[nf];
  assign above_cur = any_above(pend_q, floor_q);
  assign below_cur = any_below(pend_q, floor_q);
  assign above_nf  = any_above(pend_q, nf);
  assign below_nf  = any_below(pend_q, nf);
  assign clr       = (state == DOOR_OPEN || state == DOOR_WAIT) ? NUM_FLOORS'(1) << floor_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      floor_q  <= '0;
      dir_up   <= 1'b1;
      move_cnt <= '0;
      pend_q   <= '0;
    end else begin
      state    <= state_n;
      floor_q  <= floor_n;
      dir_up   <= dir_n;
      move_cnt <= cnt_n;
      pend_q   <= (pend_q | call_req) & ~clr;
    end
  end
  always_comb begin
    state_n = state;
    floor_n = floor_q;
    dir_n   = dir_up;
    cnt_n   = move_cnt;
    if (!emergency_stop) begin
      case (state)
        IDLE: begin
          if (hit_cur) state_n = DOOR_OPEN;
          else if (above_cur) begin
            state_n = MOVE_UP;
            dir_n   = 1'b1;
          end else if (below_cur) begin
            state_n = MOVE_DOWN;
            dir_n   = 1'b0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (!arrive) cnt_n = move_cnt + 1'b1;
          else begin
            floor_n = nf;
            cnt_n   = '0;
            if (hit_nf) state_n = DOOR_OPEN;
            else if (dir_up ? below_nf && !above_nf : above_nf && !below_nf) begin
              dir_n   = !dir_up;
              state_n = dir_up ? MOVE_DOWN : MOVE_UP;
            end else if (!above_nf && !below_nf) state_n = IDLE;
          end
        end
        DOOR_OPEN: state_n = DOOR_WAIT;
        DOOR_WAIT: state_n = wait_complete ? DOOR_CLOSE : DOOR_WAIT;
        DOOR_CLOSE: begin
          if (dir_up ? above_cur : below_cur) state_n = dir_up ? MOVE_UP : MOVE_DOWN;
          else if (dir_up ? below_cur : above_cur) begin
            dir_n   = !dir_up;
            state_n = dir_up ? MOVE_DOWN : MOVE_UP;
          end else state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_comb begin
    current_floor = floor_q;
    moving_up     = state == MOVE_UP;
    moving_down   = state == MOVE_DOWN;
    door_open     = state == DOOR_OPEN;
    door_wait     = state == DOOR_WAIT && !emergency_stop;
    door_close    = state == DOOR_CLOSE;
    pending       = pend_q;
    idle          = state == IDLE;
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed vector table, hand sequences and random run against a behavioural model
module tb_elevator_ctrl;
  localparam int N = 8, FW = 3, MC = 4;
  typedef logic [16:0] obs_t;
  typedef struct { int n; logic r; logic [N-1:0] call; logic wc; obs_t exp; } vec_t;
  logic clk = 0, rst = 0, emergency_stop = 0, wait_complete = 0;
  logic [N-1:0] call_req = '0;
  logic [FW-1:0] current_floor;
  logic moving_up, moving_down, door_open, door_wait, door_close, idle;
  logic [N-1:0] pending;
  obs_t dut_obs;
  int tests = 0, fails = 0;
  vec_t tbl[$];
  elevator_ctrl #(.NUM_FLOORS(N), .FLOOR_W(FW), .MOVE_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .emergency_stop(emergency_stop),
    .wait_complete(wait_complete), .current_floor(current_floor), .moving_up(moving_up),
    .moving_down(moving_down), .door_open(door_open), .door_wait(door_wait),
    .door_close(door_close), .pending(pending), .idle(idle)
  );
  always #5 clk = ~clk;
  assign dut_obs = {current_floor, moving_up, moving_down, door_open, door_wait, door_close, pending, idle};
  // Reference model: floors as ints, travel as a countdown of remaining cycles, calls as a bit list
  int m_floor = 0, m_mode = 0, m_dir = 1, m_left = MC;
  bit m_p [N];
  function automatic bit any_dir(int from, int d);
    for (int f = from + d; f >= 0 && f < N; f += d) if (m_p[f]) return 1;
    return 0;
  endfunction
  always @(posedge clk) begin : model
    bit np [N];
    if (rst) begin
      m_floor = 0; m_mode = 0; m_dir = 1; m_left = MC;
      for (int f = 0; f < N; f++) m_p[f] = 0;
    end else begin
      for (int f = 0; f < N; f++) np[f] = (m_p[f] | call_req[f]) && !((m_mode == 2 || m_mode == 3) && f == m_floor);
      if (!emergency_stop) begin
        case (m_mode)
          0: begin
            if (m_p[m_floor]) m_mode = 2;
            else if (any_dir(m_floor, 1)) begin m_mode = 1; m_dir = 1; end
            else if (any_dir(m_floor, -1)) begin m_mode = 1; m_dir = -1; end
          end
          1: begin
            m_left--;
            if (m_left == 0) begin
              m_left = MC;
              m_floor += m_dir;
              if (m_p[m_floor]) m_mode = 2;
              else if (!any_dir(m_floor, m_dir)) begin
                if (any_dir(m_floor, -m_dir)) m_dir = -m_dir;
                else m_mode = 0;
              end
            end
          end
          2: m_mode = 3;
          3: if (wait_complete) m_mode = 4;
          default: begin
            if (any_dir(m_floor, m_dir)) m_mode = 1;
            else if (any_dir(m_floor, -m_dir)) begin m_mode = 1; m_dir = -m_dir; end
            else m_mode = 0;
          end
        endcase
      end
      m_p = np;
    end
  end
  function automatic obs_t model_obs();
    logic [N-1:0] pv;
    for (int f = 0; f < N; f++) pv[f] = m_p[f];
    return {FW'(m_floor), m_mode == 1 && m_dir > 0, m_mode == 1 && m_dir < 0, m_mode == 2,
            m_mode == 3 && !emergency_stop, m_mode == 4, pv, m_mode == 0};
  endfunction
  function automatic obs_t ex(int fl, bit up, bit dn, bit op, bit wt, bit cl, logic [N-1:0] p, bit id);
    return {FW'(fl), up, dn, op, wt, cl, p, id};
  endfunction
  task automatic add(int n, logic r, logic [N-1:0] call, logic wc, obs_t e);
    vec_t v;
    v.n = n; v.r = r; v.call = call; v.wc = wc; v.exp = e;
    tbl.push_back(v);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string name, obs_t exp);
    tests++;
    if (dut_obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (floor,up,down,open,wait,close,pending,idle)", name, dut_obs, exp);
    end
  endtask
  initial begin
    // floor-0 self call, repeated during dwell
    add(1, 1, 8'h00, 0, ex(0,0,0,0,0,0,8'h00,1));
    add(1, 0, 8'h01, 0, ex(0,0,0,0,0,0,8'h01,1));
    add(1, 0, 8'h00, 0, ex(0,0,0,1,0,0,8'h01,0));
    add(1, 0, 8'h00, 0, ex(0,0,0,0,1,0,8'h00,0));
    add(1, 0, 8'h01, 0, ex(0,0,0,0,1,0,8'h00,0));
    add(1, 0, 8'h00, 1, ex(0,0,0,0,0,1,8'h00,0));
    add(1, 0, 8'h00, 0, ex(0,0,0,0,0,0,8'h00,1));
    // trip to floor 3, dwell, close
    add(1, 0, 8'h08, 0, ex(0,0,0,0,0,0,8'h08,1));
    add(1, 0, 8'h00, 0, ex(0,1,0,0,0,0,8'h08,0));
    add(4, 0, 8'h00, 0, ex(1,1,0,0,0,0,8'h08,0));
    add(4, 0, 8'h00, 0, ex(2,1,0,0,0,0,8'h08,0));
    add(4, 0, 8'h00, 0, ex(3,0,0,1,0,0,8'h08,0));
    add(1, 0, 8'h00, 0, ex(3,0,0,0,1,0,8'h00,0));
    add(3, 0, 8'h00, 0, ex(3,0,0,0,1,0,8'h00,0));
    add(1, 0, 8'h00, 1, ex(3,0,0,0,0,1,8'h00,0));
    add(1, 0, 8'h00, 0, ex(3,0,0,0,0,0,8'h00,1));
    // SCAN: serve 5 before reversing to 0
    add(1, 1, 8'h00, 0, ex(0,0,0,0,0,0,8'h00,1));
    add(1, 0, 8'h20, 0, ex(0,0,0,0,0,0,8'h20,1));
    add(1, 0, 8'h00, 0, ex(0,1,0,0,0,0,8'h20,0));
    add(8, 0, 8'h00, 0, ex(2,1,0,0,0,0,8'h20,0));
    add(1, 0, 8'h01, 0, ex(2,1,0,0,0,0,8'h21,0));
    add(3, 0, 8'h00, 0, ex(3,1,0,0,0,0,8'h21,0));
    add(8, 0, 8'h00, 0, ex(5,0,0,1,0,0,8'h21,0));
    add(1, 0, 8'h00, 0, ex(5,0,0,0,1,0,8'h01,0));
    add(1, 0, 8'h00, 1, ex(5,0,0,0,0,1,8'h01,0));
    add(1, 0, 8'h00, 0, ex(5,0,1,0,0,0,8'h01,0));
    add(4, 0, 8'h00, 0, ex(4,0,1,0,0,0,8'h01,0));
    add(16, 0, 8'h00, 0, ex(0,0,0,1,0,0,8'h01,0));
    add(1, 0, 8'h00, 0, ex(0,0,0,0,1,0,8'h00,0));
    add(1, 0, 8'h00, 1, ex(0,0,0,0,0,1,8'h00,0));
    add(1, 0, 8'h00, 0, ex(0,0,0,0,0,0,8'h00,1));
    // reset mid-move-down with all floors pending
    add(1, 1, 8'h00, 0, ex(0,0,0,0,0,0,8'h00,1));
    add(1, 0, 8'h20, 0, ex(0,0,0,0,0,0,8'h20,1));
    add(1, 0, 8'h00, 0, ex(0,1,0,0,0,0,8'h20,0));
    add(20, 0, 8'h00, 0, ex(5,0,0,1,0,0,8'h20,0));
    add(1, 0, 8'h00, 0, ex(5,0,0,0,1,0,8'h00,0));
    add(1, 0, 8'h00, 1, ex(5,0,0,0,0,1,8'h00,0));
    add(1, 0, 8'h00, 0, ex(5,0,0,0,0,0,8'h00,1));
    add(1, 0, 8'h01, 0, ex(5,0,0,0,0,0,8'h01,1));
    add(1, 0, 8'h00, 0, ex(5,0,1,0,0,0,8'h01,0));
    add(4, 0, 8'h00, 0, ex(4,0,1,0,0,0,8'h01,0));
    add(1, 0, 8'hFF, 0, ex(4,0,1,0,0,0,8'hFF,0));
    add(1, 1, 8'hFF, 0, ex(0,0,0,0,0,0,8'h00,1));
    add(1, 0, 8'h00, 0, ex(0,0,0,0,0,0,8'h00,1));
    // simultaneous calls above and below from idle at floor 2: up wins
    add(1, 0, 8'h04, 0, ex(0,0,0,0,0,0,8'h04,1));
    add(1, 0, 8'h00, 0, ex(0,1,0,0,0,0,8'h04,0));
    add(8, 0, 8'h00, 0, ex(2,0,0,1,0,0,8'h04,0));
    add(1, 0, 8'h00, 0, ex(2,0,0,0,1,0,8'h00,0));
    add(1, 0, 8'h00, 1, ex(2,0,0,0,0,1,8'h00,0));
    add(1, 0, 8'h00, 0, ex(2,0,0,0,0,0,8'h00,1));
    add(1, 0, 8'h21, 0, ex(2,0,0,0,0,0,8'h21,1));
    add(1, 0, 8'h00, 0, ex(2,1,0,0,0,0,8'h21,0));
    foreach (tbl[i]) begin
      rst = tbl[i].r; call_req = tbl[i].call; wait_complete = tbl[i].wc;
      repeat (tbl[i].n) step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    rst = 0; call_req = '0; wait_complete = 0;
    // emergency stop mid-travel and during dwell
    rst = 1; step(); rst = 0;
    call_req = 8'h04; step(); call_req = '0;
    step();
    repeat (6) step();
    check("estop_pre", ex(1,1,0,0,0,0,8'h04,0));
    emergency_stop = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("estop_hold%0d", i), ex(1,1,0,0,0,0,8'h04,0));
    end
    emergency_stop = 0;
    step(); check("estop_not_early", ex(1,1,0,0,0,0,8'h04,0));
    step(); check("estop_arrive", ex(2,0,0,1,0,0,8'h04,0));
    step(); check("estop_dwell", ex(2,0,0,0,1,0,8'h00,0));
    emergency_stop = 1; #1;
    check("estop_wait_low", ex(2,0,0,0,0,0,8'h00,0));
    wait_complete = 1; call_req = 8'h80; step();
    check("estop_wc_ignored", ex(2,0,0,0,0,0,8'h80,0));
    wait_complete = 0; call_req = '0; step();
    check("estop_still_wait", ex(2,0,0,0,0,0,8'h80,0));
    emergency_stop = 0; #1;
    check("estop_release", ex(2,0,0,0,1,0,8'h80,0));
    wait_complete = 1; step(); wait_complete = 0;
    check("estop_close", ex(2,0,0,0,0,1,8'h80,0));
    step(); check("estop_resume", ex(2,1,0,0,0,0,8'h80,0));
    // random traffic against the model
    rst = 1; step(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 399) == 0;
      call_req = $urandom_range(0, 5) == 0 ? N'(1 << $urandom_range(0, N - 1)) : '0;
      if ($urandom_range(0, 49) == 0) call_req = N'($urandom);
      emergency_stop = emergency_stop ? $urandom_range(0, 7) != 0 : $urandom_range(0, 39) == 0;
      wait_complete = $urandom_range(0, 3) == 0;
      step();
      tests++;
      if (dut_obs !== model_obs()) begin
        fails++;
        $display("FAIL rand cycle %0d: got %b expected %b", c, dut_obs, model_obs());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
